// File: rtl/cpu_data_mem_responder.sv
// Memory-side responder for the CPU data bus: internal synchronous RAM with programmable wait states.
// Optional MEM_RANGE_CHECK_EN adds mem_err and blocks accesses whose address[15:ADDR_W] is non-zero.
module cpu_data_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       address,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_ready,
  output logic              busy
`ifdef MEM_RANGE_CHECK_EN
  ,
  output logic              mem_err
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic                ready_q, ready_d;
  logic                oob_q, oob_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                ram_we, ram_re, rd_clr;

  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    oob_d   = oob_q;
    ready_d = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    rd_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = address[ADDR_W-1:0];
          wdata_d = wr_data;
          is_wr_d = mem_write;  // simultaneous read+write resolves to a write
          cnt_d   = 4'(WAIT_CYCLES);
`ifdef MEM_RANGE_CHECK_EN
          oob_d   = |address[15:ADDR_W];
`else
          oob_d   = 1'b0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          state_d = RESP;
          if (!oob_q) begin
            ram_we = is_wr_q;
            ram_re = !is_wr_q;
          end else begin
            rd_clr = !is_wr_q;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      oob_q     <= 1'b0;
      ready_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      oob_q   <= oob_d;
      ready_q <= ready_d;
      if (ram_re)      rd_data_q <= mem[idx_q];
      else if (rd_clr) rd_data_q <= '0;
    end
  end

  // RAM array is deliberately not reset; writes are gated by the reset-cleared FSM.
  always_ff @(posedge clk) begin
    if (ram_we) mem[idx_q] <= wdata_q;
  end

`ifdef MEM_RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= ready_d & oob_q;
  end
  assign mem_err = err_q;
`endif

  assign rd_data   = rd_data_q;
  assign mem_ready = ready_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_data_mem_responder.sv
// Directed bench for cpu_data_mem_responder: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=0 instance.
module tb_cpu_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address, wr_data, rd_data;
  logic        mem_read, mem_write, mem_ready, busy;
  logic [15:0] z_addr, z_wdata, z_rd;
  logic        z_read, z_write, z_ready, z_busy;
`ifdef MEM_RANGE_CHECK_EN
  logic        mem_err, z_err;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  cpu_data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .address(address), .wr_data(wr_data),
    .mem_read(mem_read), .mem_write(mem_write), .rd_data(rd_data),
    .mem_ready(mem_ready), .busy(busy)
`ifdef MEM_RANGE_CHECK_EN
    , .mem_err(mem_err)
`endif
  );

  cpu_data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .address(z_addr), .wr_data(z_wdata),
    .mem_read(z_read), .mem_write(z_write), .rd_data(z_rd),
    .mem_ready(z_ready), .busy(z_busy)
`ifdef MEM_RANGE_CHECK_EN
    , .mem_err(z_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called #1 after an edge with the DUT idle; returns edges from accept to ready and captured outputs.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rdv, output logic err);
    mem_read = rd; mem_write = wr; address = a; wr_data = d;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mem_ready && lat < 20);
    rdv = rd_data;
`ifdef MEM_RANGE_CHECK_EN
    err = mem_err;
`else
    err = 1'b0;
`endif
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(mem_ready), 32'd0);
    check("idle_after_resp", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, pulses;
    logic [15:0] rdv, prev;
    logic        err;

    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = '0; wr_data = '0;
    z_read = 1'b0; z_write = 1'b0; z_addr = '0; z_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: write then read
    do_access(1'b0, 1'b1, 16'h0005, 16'h1234, lat, rdv, err);
    check("t1_wr_latency", 32'(lat), 32'd3);
    do_access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, rdv, err);
    check("t1_rd_latency", 32'(lat), 32'd3);
    check("t1_rd_data", 32'(rdv), 32'h1234);

    // 2: simultaneous read+write acts as a write
    prev = rd_data;
    do_access(1'b1, 1'b1, 16'h0010, 16'hBEEF, lat, rdv, err);
    check("t2_rd_unchanged", 32'(rdv), 32'(prev));
    check("t2_latency", 32'(lat), 32'd3);
    do_access(1'b1, 1'b0, 16'h0010, 16'h0000, lat, rdv, err);
    check("t2_rd_data", 32'(rdv), 32'hBEEF);

    // 3: request while busy is ignored
    mem_read = 1'b1; address = 16'h0005;
    @(posedge clk); #1;
    address = 16'h0020;
    @(posedge clk); #1;
    mem_read = 1'b0;
    pulses = 0; rdv = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        pulses++;
        rdv = rd_data;
      end
    end
    check("t3_pulses", 32'(pulses), 32'd1);
    check("t3_rd_data", 32'(rdv), 32'h1234);

    // 4: reset mid-write aborts the commit
    do_access(1'b0, 1'b1, 16'h0007, 16'h5555, lat, rdv, err);
    mem_write = 1'b1; address = 16'h0007; wr_data = 16'hAAAA;
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("t4_ready_low", 32'(mem_ready), 32'd0);
    check("t4_busy_low", 32'(busy), 32'd0);
    check("t4_rd_data_rst", 32'(rd_data), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 16'h0007, 16'h0000, lat, rdv, err);
    check("t4_rd_data", 32'(rdv), 32'h5555);

    // 5: alias / range check
    do_access(1'b0, 1'b1, 16'h0105, 16'h0F0F, lat, rdv, err);
`ifdef MEM_RANGE_CHECK_EN
    check("t5_err_on_oob", 32'(err), 32'd1);
    do_access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, rdv, err);
    check("t5_err_in_range", 32'(err), 32'd0);
    check("t5_rd_data", 32'(rdv), 32'h1234);
`else
    do_access(1'b1, 1'b0, 16'h0005, 16'h0000, lat, rdv, err);
    check("t5_rd_alias", 32'(rdv), 32'h0F0F);
`endif

    // 6: zero wait states; held requests are accepted every 3 cycles
    z_write = 1'b1; z_addr = 16'h0003; z_wdata = 16'hCAFE;
    @(posedge clk); #1;
    z_write = 1'b0; z_read = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      check($sformatf("t6_ready_e%0d", i + 1), 32'(z_ready), ((i % 3) == 0) ? 32'd1 : 32'd0);
      if (i == 0) check("t6_wr_rd_data", 32'(z_rd), 32'h0);
      if (i == 3) check("t6_rd_data", 32'(z_rd), 32'hCAFE);
    end
    z_read = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
